// File: rtl/mult_sign.sv
// Sequential signed fixed-point multiplier (Qn.Q), shift-add over magnitudes.
// Saturates on overflow; both_image folds the i*i sign flip into the result.
module mult_sign #(
  parameter int Q = 15,
  parameter int N = 32
) (
  input  logic         i_clk,
  input  logic         i_rstn,
  input  logic         both_image,
  input  logic         i_start,
  input  logic [N-1:0] i_multiplicand_sign,
  input  logic [N-1:0] i_multiplier_sign,
  output logic         o_busy,
  output logic         o_complete,
  output logic [N-1:0] o_product_sign,
  output logic         o_overflow
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);
  localparam logic [2*N-1:0] MAXP = {{(N+1){1'b0}}, {(N-1){1'b1}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [2*N-1:0] mcand_q, mcand_d;
  logic [N-1:0]   mplier_q, mplier_d;
  logic [2*N-1:0] acc_q, acc_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           neg_q, neg_d;
  logic           busy_q, busy_d;
  logic           cmpl_q, cmpl_d;
  logic [N-1:0]   prod_q, prod_d;
  logic           ovf_q, ovf_d;

  logic [N-1:0]   mag_a, mag_b;
  logic [2*N-1:0] m;
  logic           sat;
  logic [N-1:0]   mag_r;

  // Magnitude of -2^(N-1) is 2^(N-1), exact as an unsigned N-bit value
  assign mag_a = i_multiplicand_sign[N-1] ? -i_multiplicand_sign
                                          : i_multiplicand_sign;
  assign mag_b = i_multiplier_sign[N-1] ? -i_multiplier_sign
                                        : i_multiplier_sign;

  assign m     = acc_q >> Q;
  assign sat   = (m > MAXP);
  assign mag_r = sat ? MAXP[N-1:0] : m[N-1:0];

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    busy_d   = busy_q;
    cmpl_d   = 1'b0;
    prod_d   = prod_q;
    ovf_d    = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (i_start) begin
          mcand_d  = {{N{1'b0}}, mag_a};
          mplier_d = mag_b;
          neg_d    = i_multiplicand_sign[N-1]
                   ^ i_multiplier_sign[N-1] ^ both_image;
          acc_d    = '0;
          cnt_d    = '0;
          busy_d   = 1'b1;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = FIN;
      end
      FIN: begin
        prod_d  = neg_q ? -mag_r : mag_r;
        ovf_d   = sat;
        cmpl_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      busy_q   <= 1'b0;
      cmpl_q   <= 1'b0;
      prod_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      busy_q   <= busy_d;
      cmpl_q   <= cmpl_d;
      prod_q   <= prod_d;
      ovf_q    <= ovf_d;
    end
  end

  assign o_busy         = busy_q;
  assign o_complete     = cmpl_q;
  assign o_product_sign = prod_q;
  assign o_overflow     = ovf_q;

endmodule

// File: tb/tb_mult_sign.sv
// Directed bench for mult_sign (N=32, Q=15).
// Hand-computed products, latency, handshake and reset checks.
module tb_mult_sign;

  logic        clk;
  logic        rstn;
  logic        bi;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        cmpl;
  logic [31:0] prod;
  logic        ovf;

  int tests;
  int fails;

  mult_sign #(.Q(15), .N(32)) dut (
    .i_clk               (clk),
    .i_rstn              (rstn),
    .both_image          (bi),
    .i_start             (start),
    .i_multiplicand_sign (a),
    .i_multiplier_sign   (b),
    .o_busy              (busy),
    .o_complete          (cmpl),
    .o_product_sign      (prod),
    .o_overflow          (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge where o_complete is seen.
  task automatic run(input string tag,
                     input logic [31:0] va,
                     input logic [31:0] vb,
                     input logic vbi,
                     input logic [31:0] ep,
                     input logic eo);
    int k;
    a = va; b = vb; bi = vbi; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    a = 32'hDEAD_BEEF; b = 32'h1234_5678; bi = ~vbi;
    chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
    k = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (cmpl) begin
        k = i;
        break;
      end
    end
    chk({tag, "_lat"}, k, 32'd33);
    chk({tag, "_prod"}, prod, ep);
    chk({tag, "_ovf"}, {31'd0, ovf}, {31'd0, eo});
    chk({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int seen;
    tests = 0;
    fails = 0;
    rstn = 1'b0; start = 1'b0; bi = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (cmpl || busy) seen++;
    end
    chk("idle_pulse", seen, 32'd0);
    chk("rst_prod", prod, 32'd0);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);

    run("pos", 32'h0000_C000, 32'h0001_0000, 1'b0, 32'h0001_8000, 1'b0);
    run("neg", 32'hFFFF_4000, 32'h0001_0000, 1'b0, 32'hFFFE_8000, 1'b0);
    run("img", 32'hFFFF_4000, 32'h0001_0000, 1'b1, 32'h0001_8000, 1'b0);
    run("one", 32'h0000_8000, 32'h0000_8000, 1'b1, 32'hFFFF_8000, 1'b0);
    run("ovp", 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0, 32'h7FFF_FFFF, 1'b1);
    run("ovn", 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 32'h8000_0001, 1'b1);
    run("trz", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b0);

    @(posedge clk);
    @(negedge clk);
    chk("hold_cmpl", {31'd0, cmpl}, 32'd0);
    chk("hold_prod", prod, 32'h0000_0000);

    // Second start mid-operation must be ignored
    a = 32'h0000_C000; b = 32'h0001_0000; bi = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    a = 32'h7FFF_FFFF; b = 32'h7FFF_FFFF; bi = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (cmpl) begin
        seen = 1;
        break;
      end
    end
    chk("ign_done", seen, 32'd1);
    chk("ign_prod", prod, 32'h0001_8000);
    chk("ign_ovf", {31'd0, ovf}, 32'd0);
    @(negedge clk);
    chk("ign_no_restart", {31'd0, busy}, 32'd0);

    // Reset in the middle of BUSY
    a = 32'h0000_8000; b = 32'h0000_8000; bi = 1'b1; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_prod", prod, 32'd0);
    chk("arst_ovf", {31'd0, ovf}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (cmpl) seen++;
    end
    chk("arst_no_cmpl", seen, 32'd0);

    run("fresh", 32'hFFFF_4000, 32'hFFFF_0000, 1'b0, 32'h0001_8000, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mult_sign.md
Name: mult_sign

Overview:
- Sequential signed fixed-point multiplier. Counterpart to the signed divider in the complex-arithmetic datapath of the finder.
- Takes two N-bit two's-complement operands, each with Q fractional bits, and returns their product in the same format. Uses an iterative shift-add over operand magnitudes.
- Start/complete handshake matches the divider.
- both_image flag negates the result when both operands are imaginary parts (i*i = -1), so the caller can form the real term of a complex product directly.

Parameters:
- Q, 15, number of fractional bits in operands and result; legal range 0 <= Q < N.
- N, 32, total word width including sign bit.

Ports:
- i_clk  in  1  clock; all state updates on rising edge.
- i_rstn  in  1  asynchronous active-low reset.
- both_image  in  1  1 = both operands imaginary; final sign inverted. Sampled with i_start.
- i_start  in  1  one-cycle request; accepted only in IDLE.
- i_multiplicand_sign  in  N  two's-complement operand A. Sampled with i_start.
- i_multiplier_sign  in  N  two's-complement operand B. Sampled with i_start.
- o_busy  out  1  high while an operation is in progress (states BUSY and FIN).
- o_complete  out  1  one-cycle pulse when the result is valid.
- o_product_sign  out  N  two's-complement result; held until the next completion.
- o_overflow  out  1  result saturated; held with o_product_sign.

Behaviour:
- Reset (asynchronous, any state):
  - Go to IDLE and abort any operation in flight.
  - o_busy=0, o_complete=0, o_product_sign=0, o_overflow=0; internal registers cleared.
- Operand capture:
  - On i_start=1 in IDLE, register the magnitudes |A| and |B| as N-bit unsigned values, so -2^(N-1) is represented exactly.
  - Register neg = A[N-1] ^ B[N-1] ^ both_image.
  - Clear the 2N-bit accumulator and the iteration counter.
- States:
  - IDLE: o_busy=0. Goes to BUSY on i_start; otherwise stays.
  - BUSY: N iterations, one per clock. Each iteration: if multiplier LSB=1, add the shifted multiplicand into the accumulator; then shift the multiplicand left 1 and the multiplier right 1. After iteration N-1, go to FIN.
  - FIN: one cycle.
    - Compute m = accumulator >> Q (truncation of magnitude, i.e. rounds toward zero).
    - If m > 2^(N-1)-1: o_overflow=1, o_product_sign = neg ? -(2^(N-1)-1) : 2^(N-1)-1.
    - Else: o_overflow=0, o_product_sign = neg ? -m : m.
    - A zero magnitude always gives all-zero output with sign bit 0, regardless of neg.
    - Register the result, pulse o_complete=1 for exactly one cycle, return to IDLE.
- Latency: i_start sampled at edge 0. o_complete is high in the cycle after edge N+1, i.e. N+1 clocks after acceptance.
- Back-to-back operation: a new i_start is accepted in the same cycle o_complete is high, since the FSM is already in IDLE.
- i_start while o_busy=1 is ignored. Operand and both_image changes during BUSY or FIN have no effect.
- -2^(N-1) as a result is never produced; it is reported as overflow and saturates to -(2^(N-1)-1).
- Between completions, o_product_sign and o_overflow hold their last values.

Test Plan (N=32, Q=15):
- Reset released; idle 5 cycles -> all outputs 0; o_complete never pulses.
- A=0x0000C000 (1.5), B=0x00010000 (2.0), both_image=0 -> exactly 33 clocks later o_complete=1 for 1 cycle; product 0x00018000; overflow 0.
- A=0xFFFF4000 (-1.5), B=0x00010000 -> product 0xFFFE8000 (-3.0).
- Same operands with both_image=1 -> product 0x00018000.
- A=0x00008000 (1.0), B=0x00008000, both_image=1 -> product 0xFFFF8000.
- Overflow and truncation:
  - A=B=0x7FFFFFFF -> product 0x7FFFFFFF, overflow 1.
  - A=0x80000000, B=0x7FFFFFFF -> product 0x80000001, overflow 1.
  - A=0xFFFFFFFF, B=0x00000001 -> product 0x00000000, overflow 0.
- Handshake and reset:
  - Second i_start 10 cycles into BUSY with different operands -> ignored; first result delivered unchanged.
  - i_rstn pulled low mid-BUSY -> outputs 0 immediately; no o_complete.
  - Fresh start after reset -> correct result.
